// File: rtl/rf_wb_scheduler_pkg.sv
// Shared definitions for the register-file writeback scheduler: the
// writeback-source select encodings driven into the regfile mux, default
// sizing for the measurement result buffer, and the arbiter grant type.
package rf_wb_scheduler_pkg;

   // Writeback-source select codes seen by the regfile writeback mux
   localparam logic [2:0] REGSRC_MEM  = 3'd0;
   localparam logic [2:0] REGSRC_ALU  = 3'd1;
   localparam logic [2:0] REGSRC_MEA  = 3'd2;
   localparam logic [2:0] REGSRC_COMP = 3'd3;
   localparam logic [2:0] REGSRC_IMM  = 3'd4;

   // Default measurement FIFO depth and head starvation limit
   localparam int MEA_FIFO_DEPTH = 4;
   localparam int MEA_AGE_MAX    = 8;

   // One buffered measurement result
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } mea_entry_t;

   // Which source owns the write port this cycle
   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_MEM  = 2'd1,
      GRANT_MEA  = 2'd2,
      GRANT_PIPE = 2'd3
   } grant_t;

   // One-hot mask for a register index; x0 never maps to a bit
   function automatic logic [31:0] rdOneHot(input logic [4:0] rd);
      logic [31:0] mask;
      mask = 32'd0;
      if (rd != 5'd0) begin
         mask[rd] = 1'b1;
      end
      return mask;
   endfunction

endpackage

// File: rtl/rf_wb_scheduler_mea_fifo.sv
// Small synchronous FIFO holding measurement results ({rd, data}) until
// the writeback scheduler can grant them the register-file write port.
// Pushes are ignored while full and pops while empty, so the caller may
// issue both in the same cycle at any non-full occupancy.
module mea_result_fifo
   import rf_wb_scheduler_pkg::*;
#(
   parameter int DEPTH = MEA_FIFO_DEPTH,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [4:0]    i_push_rd,
   input  logic [31:0]   i_push_data,
   input  logic          i_pop,
   output logic [4:0]    o_head_rd,
   output logic [31:0]   o_head_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   mea_entry_t    r_storage [DEPTH];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;
   logic          w_doPush;
   logic          w_doPop;
   mea_entry_t    w_head;

   assign o_full   = (r_count == FULL_COUNT);
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign w_doPush = i_push && !o_full;
   assign w_doPop  = i_pop && !o_empty;

   assign w_head      = r_storage[r_rdPtr];
   assign o_head_rd   = w_head.rd;
   assign o_head_data = w_head.data;

   // Entry storage: written only on an accepted push, no reset needed
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_storage[r_wrPtr] <= '{rd: i_push_rd, data: i_push_data};
      end
   end

   // Pointers wrap naturally because the depth is a power of two
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
      end
   end

   // Occupancy: simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler. Shares the single regfile write port
// between load returns (never stallable), buffered measurement results and
// in-order pipeline results. A measurement head that has waited too long,
// or a full buffer, outranks the pipeline so results cannot starve. A
// scoreboard marks registers still waiting on a measurement so control can
// stall dependent reads; a pipe or load write to such a register raises a
// sticky write-after-write flag.
module rf_wb_scheduler
   import rf_wb_scheduler_pkg::*;
#(
   parameter int MEA_DEPTH = MEA_FIFO_DEPTH,
   parameter int AGE_MAX   = MEA_AGE_MAX
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_pipe_valid,
   output logic        o_pipe_ready,
   input  logic [4:0]  i_pipe_rd,
   input  logic [2:0]  i_pipe_sel,
   input  logic [31:0] i_pipe_data,
   input  logic        i_mem_valid,
   input  logic [4:0]  i_mem_rd,
   input  logic [31:0] i_mem_data,
   input  logic        i_mea_issue,
   input  logic [4:0]  i_mea_issue_rd,
   input  logic        i_mea_valid,
   output logic        o_mea_ready,
   input  logic [4:0]  i_mea_rd,
   input  logic [31:0] i_mea_data,
   output logic [31:0] o_busy_mask,
   output logic        o_wb_en,
   output logic [4:0]  o_wb_rd,
   output logic [2:0]  o_wb_sel,
   output logic [31:0] o_wb_data,
   output logic        o_waw_err
);

   localparam int CW = $clog2(MEA_DEPTH) + 1;
   localparam int AW = $clog2(AGE_MAX + 1);
   localparam logic [CW-1:0] DEPTH_COUNT = CW'(MEA_DEPTH);
   localparam logic [AW-1:0] AGE_SAT     = AW'(AGE_MAX);

   logic          w_fifoFull;
   logic          w_fifoEmpty;
   logic [CW-1:0] w_fifoCount;
   logic [4:0]    w_headRd;
   logic [31:0]   w_headData;
   logic          w_meaReady;
   logic          w_push;
   logic          w_pop;
   logic          w_meaUrgent;
   grant_t        w_grant;
   logic          w_pipeReady;
   logic          w_nextValid;
   logic [4:0]    w_nextRd;
   logic [2:0]    w_nextSel;
   logic [31:0]   w_nextData;
   logic          w_nextEn;
   logic          w_wawHit;
   logic [31:0]   w_busyNext;

   logic [AW-1:0] r_headAge;
   logic [31:0]   r_busy;
   logic          r_wawErr;
   logic          r_wbEn;
   logic [4:0]    r_wbRd;
   logic [2:0]    r_wbSel;
   logic [31:0]   r_wbData;
   logic          r_wbFromMea;

   assign w_meaReady  = (w_fifoCount < DEPTH_COUNT);
   assign w_push      = i_mea_valid && w_meaReady;
   assign w_pop       = (w_grant == GRANT_MEA);
   assign w_meaUrgent = !w_fifoEmpty && (w_fifoFull || (r_headAge >= AGE_SAT));

   mea_result_fifo #(
      .DEPTH(MEA_DEPTH)
   ) u_meaFifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_push),
      .i_push_rd  (i_mea_rd),
      .i_push_data(i_mea_data),
      .i_pop      (w_pop),
      .o_head_rd  (w_headRd),
      .o_head_data(w_headData),
      .o_full     (w_fifoFull),
      .o_empty    (w_fifoEmpty),
      .o_count    (w_fifoCount)
   );

   // Fixed-priority arbiter: loads, then an urgent measurement, then the
   // pipeline, then any waiting measurement
   always_comb begin
      w_grant     = GRANT_NONE;
      w_pipeReady = 1'b0;
      if (i_mem_valid) begin
         w_grant = GRANT_MEM;
      end else if (w_meaUrgent) begin
         w_grant = GRANT_MEA;
      end else begin
         w_pipeReady = 1'b1;
         if (i_pipe_valid) begin
            w_grant = GRANT_PIPE;
         end else if (!w_fifoEmpty) begin
            w_grant = GRANT_MEA;
         end
      end
   end

   // Route the granted source's destination, select code and data
   always_comb begin
      w_nextValid = 1'b0;
      w_nextRd    = r_wbRd;
      w_nextSel   = r_wbSel;
      w_nextData  = r_wbData;
      case (w_grant)
         GRANT_MEM: begin
            w_nextValid = 1'b1;
            w_nextRd    = i_mem_rd;
            w_nextSel   = REGSRC_MEM;
            w_nextData  = i_mem_data;
         end
         GRANT_MEA: begin
            w_nextValid = 1'b1;
            w_nextRd    = w_headRd;
            w_nextSel   = REGSRC_MEA;
            w_nextData  = w_headData;
         end
         GRANT_PIPE: begin
            w_nextValid = 1'b1;
            w_nextRd    = i_pipe_rd;
            w_nextSel   = i_pipe_sel;
            w_nextData  = i_pipe_data;
         end
         default: begin
            w_nextValid = 1'b0;
         end
      endcase
   end

   // Writes to x0 still consume the grant but never enable the regfile
   assign w_nextEn = w_nextValid && (w_nextRd != 5'd0);

   // A load or pipe write landing on a register still owed a measurement
   assign w_wawHit = w_nextEn && ((w_grant == GRANT_MEM) || (w_grant == GRANT_PIPE))
                     && r_busy[w_nextRd];

   // Busy bits clear once a measurement write has been presented to the
   // regfile; a same-cycle issue to that register re-sets it
   always_comb begin
      w_busyNext = r_busy;
      if (r_wbFromMea) begin
         w_busyNext = w_busyNext & ~rdOneHot(r_wbRd);
      end
      if (i_mea_issue) begin
         w_busyNext = w_busyNext | rdOneHot(i_mea_issue_rd);
      end
   end

   // Registered writeback port, one cycle after the grant
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wbEn      <= 1'b0;
         r_wbRd      <= 5'd0;
         r_wbSel     <= REGSRC_ALU;
         r_wbData    <= 32'd0;
         r_wbFromMea <= 1'b0;
      end else begin
         r_wbEn      <= w_nextEn;
         r_wbRd      <= w_nextRd;
         r_wbSel     <= w_nextSel;
         r_wbData    <= w_nextData;
         r_wbFromMea <= w_nextEn && (w_grant == GRANT_MEA);
      end
   end

   // Head age: restarts whenever a new entry becomes head, saturates
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_headAge <= '0;
      end else if (w_pop || w_fifoEmpty) begin
         r_headAge <= '0;
      end else if (r_headAge < AGE_SAT) begin
         r_headAge <= r_headAge + 1'b1;
      end
   end

   // Scoreboard of registers awaiting a measurement result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy <= 32'd0;
      end else begin
         r_busy <= w_busyNext;
      end
   end

   // Sticky write-after-write error, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wawErr <= 1'b0;
      end else if (w_wawHit) begin
         r_wawErr <= 1'b1;
      end
   end

   assign o_pipe_ready = w_pipeReady;
   assign o_mea_ready  = w_meaReady;
   assign o_busy_mask  = r_busy;
   assign o_waw_err    = r_wawErr;
   assign o_wb_en      = r_wbEn;
   assign o_wb_rd      = r_wbRd;
   assign o_wb_sel     = r_wbSel;
   assign o_wb_data    = r_wbData;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for the writeback scheduler. Each step records the write
// it should cause in an expectation queue; after the clock edge the queue
// head is popped and compared with the registered writeback port.
module tb_rf_wb_scheduler;
   import rf_wb_scheduler_pkg::*;

   typedef struct {
      logic        en;
      logic [4:0]  rd;
      logic [2:0]  sel;
      logic [31:0] data;
   } wbExp_t;

   logic        clk;
   logic        rst_n;
   logic        i_pipe_valid;
   logic        o_pipe_ready;
   logic [4:0]  i_pipe_rd;
   logic [2:0]  i_pipe_sel;
   logic [31:0] i_pipe_data;
   logic        i_mem_valid;
   logic [4:0]  i_mem_rd;
   logic [31:0] i_mem_data;
   logic        i_mea_issue;
   logic [4:0]  i_mea_issue_rd;
   logic        i_mea_valid;
   logic        o_mea_ready;
   logic [4:0]  i_mea_rd;
   logic [31:0] i_mea_data;
   logic [31:0] o_busy_mask;
   logic        o_wb_en;
   logic [4:0]  o_wb_rd;
   logic [2:0]  o_wb_sel;
   logic [31:0] o_wb_data;
   logic        o_waw_err;

   wbExp_t expQ[$];
   int     vectors;
   int     miscompares;

   rf_wb_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_pipe_valid  (i_pipe_valid),
      .o_pipe_ready  (o_pipe_ready),
      .i_pipe_rd     (i_pipe_rd),
      .i_pipe_sel    (i_pipe_sel),
      .i_pipe_data   (i_pipe_data),
      .i_mem_valid   (i_mem_valid),
      .i_mem_rd      (i_mem_rd),
      .i_mem_data    (i_mem_data),
      .i_mea_issue   (i_mea_issue),
      .i_mea_issue_rd(i_mea_issue_rd),
      .i_mea_valid   (i_mea_valid),
      .o_mea_ready   (o_mea_ready),
      .i_mea_rd      (i_mea_rd),
      .i_mea_data    (i_mea_data),
      .o_busy_mask   (o_busy_mask),
      .o_wb_en       (o_wb_en),
      .o_wb_rd       (o_wb_rd),
      .o_wb_sel      (o_wb_sel),
      .o_wb_data     (o_wb_data),
      .o_waw_err     (o_waw_err)
   );

   // Free-running clock, 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation
   task automatic checkVal(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Record the write the next clock edge should produce
   task automatic expectWb(input logic en, input logic [4:0] rd,
                           input logic [2:0] sel, input logic [31:0] data);
      wbExp_t e;
      e.en   = en;
      e.rd   = rd;
      e.sel  = sel;
      e.data = data;
      expQ.push_back(e);
   endtask

   // Pop the oldest expectation and compare it with the writeback port
   task automatic checkOutput(input string tag);
      wbExp_t e;
      if (expQ.size() == 0) begin
         vectors++;
         miscompares++;
         $error("[TB] FAIL %s observed=no-expectation expected=queued-write", tag);
      end else begin
         e = expQ.pop_front();
         checkVal({tag, ".en"}, {31'd0, o_wb_en}, {31'd0, e.en});
         if (e.en) begin
            checkVal({tag, ".rd"},   {27'd0, o_wb_rd},  {27'd0, e.rd});
            checkVal({tag, ".sel"},  {29'd0, o_wb_sel}, {29'd0, e.sel});
            checkVal({tag, ".data"}, o_wb_data,         e.data);
         end
      end
   endtask

   // Advance one clock and let registered outputs settle
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Return all request inputs to idle
   task automatic clearInputs();
      i_pipe_valid   = 1'b0;
      i_pipe_rd      = 5'd0;
      i_pipe_sel     = REGSRC_ALU;
      i_pipe_data    = 32'd0;
      i_mem_valid    = 1'b0;
      i_mem_rd       = 5'd0;
      i_mem_data     = 32'd0;
      i_mea_issue    = 1'b0;
      i_mea_issue_rd = 5'd0;
      i_mea_valid    = 1'b0;
      i_mea_rd       = 5'd0;
      i_mea_data     = 32'd0;
   endtask

   // Directed sequence of scheduler scenarios
   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      clearInputs();
      applyStimulus();
      applyStimulus();

      checkVal("reset.wb_en",     {31'd0, o_wb_en},      32'd0);
      checkVal("reset.wb_rd",     {27'd0, o_wb_rd},      32'd0);
      checkVal("reset.wb_sel",    {29'd0, o_wb_sel},     {29'd0, REGSRC_ALU});
      checkVal("reset.wb_data",   o_wb_data,             32'd0);
      checkVal("reset.busy",      o_busy_mask,           32'd0);
      checkVal("reset.waw",       {31'd0, o_waw_err},    32'd0);
      checkVal("reset.mea_ready", {31'd0, o_mea_ready},  32'd1);
      checkVal("reset.pipe_ready",{31'd0, o_pipe_ready}, 32'd1);
      rst_n = 1'b1;

      // Pipeline result alone
      i_pipe_valid = 1'b1;
      i_pipe_rd    = 5'd5;
      i_pipe_sel   = REGSRC_ALU;
      i_pipe_data  = 32'h1234;
      #1;
      checkVal("pipe.ready", {31'd0, o_pipe_ready}, 32'd1);
      expectWb(1'b1, 5'd5, REGSRC_ALU, 32'h1234);
      applyStimulus();
      clearInputs();
      checkOutput("pipe");

      // Load return collides with a pipeline result
      i_mem_valid  = 1'b1;
      i_mem_rd     = 5'd3;
      i_mem_data   = 32'hAAAA;
      i_pipe_valid = 1'b1;
      i_pipe_rd    = 5'd4;
      i_pipe_sel   = REGSRC_IMM;
      i_pipe_data  = 32'h4444;
      #1;
      checkVal("collide.ready_lo", {31'd0, o_pipe_ready}, 32'd0);
      expectWb(1'b1, 5'd3, REGSRC_MEM, 32'hAAAA);
      applyStimulus();
      i_mem_valid = 1'b0;
      #1;
      checkVal("collide.ready_hi", {31'd0, o_pipe_ready}, 32'd1);
      checkOutput("collide.mem");
      expectWb(1'b1, 5'd4, REGSRC_IMM, 32'h4444);
      applyStimulus();
      clearInputs();
      checkOutput("collide.pipe");

      // Scoreboard set on issue, cleared after the measurement write
      i_mea_issue    = 1'b1;
      i_mea_issue_rd = 5'd7;
      applyStimulus();
      clearInputs();
      checkVal("sb.busy_set", o_busy_mask, 32'h80);
      i_mea_valid = 1'b1;
      i_mea_rd    = 5'd7;
      i_mea_data  = 32'h1;
      #1;
      checkVal("sb.mea_ready", {31'd0, o_mea_ready}, 32'd1);
      applyStimulus();
      clearInputs();
      #1;
      checkVal("sb.pipe_ready", {31'd0, o_pipe_ready}, 32'd1);
      expectWb(1'b1, 5'd7, REGSRC_MEA, 32'h1);
      applyStimulus();
      checkOutput("sb.write");
      expectWb(1'b0, 5'd0, REGSRC_ALU, 32'd0);
      applyStimulus();
      checkOutput("sb.after");
      checkVal("sb.busy_clr", o_busy_mask, 32'h0);

      // Pipe write to a register still awaiting a measurement
      i_mea_issue    = 1'b1;
      i_mea_issue_rd = 5'd9;
      applyStimulus();
      clearInputs();
      checkVal("waw.busy", o_busy_mask, 32'h200);
      checkVal("waw.pre",  {31'd0, o_waw_err}, 32'd0);
      i_pipe_valid = 1'b1;
      i_pipe_rd    = 5'd9;
      i_pipe_sel   = REGSRC_ALU;
      i_pipe_data  = 32'h99;
      expectWb(1'b1, 5'd9, REGSRC_ALU, 32'h99);
      applyStimulus();
      clearInputs();
      checkOutput("waw.write");
      checkVal("waw.set", {31'd0, o_waw_err}, 32'd1);
      expectWb(1'b0, 5'd0, REGSRC_ALU, 32'd0);
      applyStimulus();
      checkOutput("waw.idle");
      checkVal("waw.held", {31'd0, o_waw_err}, 32'd1);

      // Measurement result addressed to x0 is consumed silently
      i_mea_valid = 1'b1;
      i_mea_rd    = 5'd0;
      i_mea_data  = 32'hDEAD;
      applyStimulus();
      clearInputs();
      expectWb(1'b0, 5'd0, REGSRC_MEA, 32'hDEAD);
      applyStimulus();
      checkOutput("rd0.pop");

      // Starvation: pipe stays valid while one measurement waits
      i_pipe_valid = 1'b1;
      i_pipe_rd    = 5'd6;
      i_pipe_sel   = REGSRC_COMP;
      i_pipe_data  = 32'h100;
      i_mea_valid  = 1'b1;
      i_mea_rd     = 5'd12;
      i_mea_data   = 32'hC0DE;
      #1;
      checkVal("starve.push_ready", {31'd0, o_pipe_ready}, 32'd1);
      expectWb(1'b1, 5'd6, REGSRC_COMP, 32'h100);
      applyStimulus();
      i_mea_valid = 1'b0;
      checkOutput("starve.push");
      for (int k = 0; k < 8; k++) begin
         i_pipe_data = 32'h101 + 32'(k);
         #1;
         checkVal("starve.pipe_ready", {31'd0, o_pipe_ready}, 32'd1);
         expectWb(1'b1, 5'd6, REGSRC_COMP, 32'h101 + 32'(k));
         applyStimulus();
         checkOutput("starve.pipe");
      end
      i_pipe_data = 32'h200;
      #1;
      checkVal("starve.urgent_ready", {31'd0, o_pipe_ready}, 32'd0);
      expectWb(1'b1, 5'd12, REGSRC_MEA, 32'hC0DE);
      applyStimulus();
      checkOutput("starve.mea");
      #1;
      checkVal("starve.resume_ready", {31'd0, o_pipe_ready}, 32'd1);
      expectWb(1'b1, 5'd6, REGSRC_COMP, 32'h200);
      applyStimulus();
      clearInputs();
      checkOutput("starve.resume");

      // Fill the FIFO while loads hold the port, then drain
      i_mem_valid  = 1'b1;
      i_mem_rd     = 5'd1;
      i_pipe_valid = 1'b1;
      i_pipe_rd    = 5'd2;
      i_pipe_sel   = REGSRC_ALU;
      i_pipe_data  = 32'h2222;
      for (int k = 0; k < 4; k++) begin
         i_mem_data  = 32'h1000 + 32'(k);
         i_mea_valid = 1'b1;
         i_mea_rd    = 5'd20 + 5'(k);
         i_mea_data  = 32'hE0 + 32'(k);
         #1;
         checkVal("full.mea_ready", {31'd0, o_mea_ready}, 32'd1);
         expectWb(1'b1, 5'd1, REGSRC_MEM, 32'h1000 + 32'(k));
         applyStimulus();
         checkOutput("full.mem");
      end
      i_mea_valid = 1'b0;
      #1;
      checkVal("full.not_ready", {31'd0, o_mea_ready}, 32'd0);
      i_mem_valid = 1'b0;
      #1;
      checkVal("full.pipe_blocked", {31'd0, o_pipe_ready}, 32'd0);
      expectWb(1'b1, 5'd20, REGSRC_MEA, 32'hE0);
      applyStimulus();
      checkOutput("full.drain0");
      #1;
      checkVal("full.pipe_back", {31'd0, o_pipe_ready}, 32'd1);
      checkVal("full.ready_back", {31'd0, o_mea_ready}, 32'd1);
      expectWb(1'b1, 5'd2, REGSRC_ALU, 32'h2222);
      applyStimulus();
      clearInputs();
      checkOutput("full.pipe");
      expectWb(1'b1, 5'd21, REGSRC_MEA, 32'hE1);
      applyStimulus();
      checkOutput("full.drain1");

      // Reset while two entries remain and a busy bit is set
      rst_n = 1'b0;
      expectWb(1'b0, 5'd0, REGSRC_ALU, 32'd0);
      applyStimulus();
      checkOutput("midrst");
      checkVal("midrst.sel",   {29'd0, o_wb_sel},    {29'd0, REGSRC_ALU});
      checkVal("midrst.data",  o_wb_data,            32'd0);
      checkVal("midrst.busy",  o_busy_mask,          32'd0);
      checkVal("midrst.waw",   {31'd0, o_waw_err},   32'd0);
      checkVal("midrst.ready", {31'd0, o_mea_ready}, 32'd1);
      rst_n = 1'b1;
      expectWb(1'b0, 5'd0, REGSRC_ALU, 32'd0);
      applyStimulus();
      checkOutput("midrst.fifo_empty");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
